// File: rtl/mem_responder.sv
// Unified instruction/data memory responder: single-outstanding word access
// with LATENCY wait states, misalignment/range checking, registered outputs.
module mem_responder #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 256,
  parameter logic [WIDTH-1:0] BASE_ADDR = WIDTH'(32'h0040_0000),
  parameter int               LATENCY   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             ready,
  output logic             err,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] wordIdx;
  logic [AW-1:0]    memIdx;
  logic             accErr;
  logic             memWr;

  // Modulo subtraction makes addresses below BASE_ADDR land on a huge index,
  // so they are rejected by the range check instead of aliasing.
  always_comb begin
    offset  = addr_q - BASE_ADDR;
    wordIdx = offset >> 2;
    memIdx  = offset[AW+1:2];
    accErr  = (addr_q[1:0] != 2'b00) || (wordIdx >= WIDTH'(DEPTH));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = err_q;
    busy_d  = busy_q;
    memWr   = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = 4'(LATENCY);
          busy_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = accErr;
          if (accErr) begin
            rdata_d = '0;
          end else if (!we_q) begin
            rdata_d = mem[memIdx];
          end else begin
            memWr = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // The array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (memWr) begin
      mem[memIdx] <= wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder: a LATENCY=2 instance for most
// steps plus a LATENCY=0 instance for the minimum-latency path.
module tb_mem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } expT;

  logic        clk;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata, rdata;
  logic        ready, err, busy;
  logic        req0, we0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ready0, err0, busy0;

  bit          sel;
  logic [31:0] rdataS;
  logic        readyS, errS, busyS;

  expT sb[$];
  int  total = 0;
  int  bad   = 0;

  mem_responder #(.WIDTH(32), .DEPTH(256), .BASE_ADDR(32'h0040_0000), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .busy(busy)
  );

  mem_responder #(.WIDTH(32), .DEPTH(256), .BASE_ADDR(32'h0040_0000), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
  );

  assign rdataS = sel ? rdata0 : rdata;
  assign readyS = sel ? ready0 : ready;
  assign errS   = sel ? err0   : err;
  assign busyS  = sel ? busy0  : busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated access: drive req for a single cycle, wait (bounded) for the
  // ready pulse, then compare latency and the scoreboard entry.
  task automatic applyStimulus(input bit l0, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] expData,
                               input logic expErr, input string tag);
    expT e;
    int  n;
    int  lat;
    lat    = l0 ? 0 : 2;
    e.data = expData;
    e.err  = expErr;
    sb.push_back(e);
    sel = l0;
    if (l0) begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req = 1'b1; we = w; addr = a; wdata = d;
    end
    @(negedge clk);
    n    = 1;
    req  = 1'b0;
    req0 = 1'b0;
    checkOutput({tag, "_busy"}, 32'(busyS), 32'd1);
    while (!readyS && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'(lat + 2));
    e = sb.pop_front();
    checkOutput({tag, "_rdata"}, rdataS, e.data);
    checkOutput({tag, "_err"}, 32'(errS), 32'(e.err));
    @(negedge clk);
    checkOutput({tag, "_readyLow"}, 32'(readyS), 32'd0);
    checkOutput({tag, "_busyLow"}, 32'(busyS), 32'd0);
  endtask

  initial begin
    expT e;
    int  pulses;
    int  cyc;
    int  last;
    int  extra;

    sel = 1'b0;
    rst = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_ready", 32'(ready), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("idle_outs", {rdata[28:0], ready, err, busy}, 32'h0);
    end

    applyStimulus(1'b0, 1'b1, 32'h0040_0008, 32'hDEAD_BEEF, 32'h0, 1'b0, "wr8");
    applyStimulus(1'b0, 1'b0, 32'h0040_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd8");
    applyStimulus(1'b0, 1'b1, 32'h0040_0004, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0, "wr4");
    applyStimulus(1'b0, 1'b1, 32'h0040_0006, 32'h5555_5555, 32'h0, 1'b1, "wrMisal");
    applyStimulus(1'b0, 1'b0, 32'h0040_0004, 32'h0, 32'hCAFE_F00D, 1'b0, "rd4");
    applyStimulus(1'b0, 1'b0, 32'h0040_0400, 32'h0, 32'h0, 1'b1, "rdHigh");
    applyStimulus(1'b0, 1'b0, 32'h003F_FFFC, 32'h0, 32'h0, 1'b1, "rdBelow");
    applyStimulus(1'b0, 1'b1, 32'h0040_0000, 32'h1111_0000, 32'h0, 1'b0, "wr0");

    // Held req with alternating address: a pulse every LATENCY+3 cycles.
    sel  = 1'b0;
    we   = 1'b0;
    req  = 1'b1;
    addr = 32'h0040_0000;
    e.data = 32'h1111_0000; e.err = 1'b0; sb.push_back(e);
    pulses = 0; cyc = 0; last = 0;
    while (pulses < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ready) begin
        e = sb.pop_front();
        checkOutput("held_rdata", rdata, e.data);
        checkOutput("held_err", 32'(err), 32'(e.err));
        checkOutput("held_gap", 32'(cyc - last), (pulses == 0) ? 32'd4 : 32'd5);
        last = cyc;
        pulses++;
        if (pulses < 4) begin
          addr   = pulses[0] ? 32'h0040_0004 : 32'h0040_0000;
          e.data = pulses[0] ? 32'hCAFE_F00D : 32'h1111_0000;
          e.err  = 1'b0;
          sb.push_back(e);
        end else begin
          req = 1'b0;
        end
      end
    end
    req = 1'b0;
    checkOutput("held_pulses", 32'(pulses), 32'd4);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready) extra++;
    end
    checkOutput("held_extra", 32'(extra), 32'd0);
    checkOutput("held_sbEmpty", 32'(sb.size()), 32'd0);
    sb.delete();

    applyStimulus(1'b0, 1'b1, 32'h0040_0010, 32'hA5A5_A5A5, 32'hCAFE_F00D, 1'b0, "wr10");

    // Abandon a write by asserting reset while it is waiting.
    req = 1'b1; we = 1'b1; addr = 32'h0040_0010; wdata = 32'h1234_5678;
    @(negedge clk);
    req = 1'b0;
    checkOutput("abort_busyBefore", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("abort_rdata", rdata, 32'h0);
    checkOutput("abort_ready", 32'(ready), 32'd0);
    checkOutput("abort_err", 32'(err), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (ready) extra++;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ready || busy) extra++;
    end
    checkOutput("abort_noReady", 32'(extra), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0040_0010, 32'h0, 32'hA5A5_A5A5, 1'b0, "rd10");

    applyStimulus(1'b1, 1'b1, 32'h0040_0020, 32'h0BAD_F00D, 32'h0, 1'b0, "l0wr");
    applyStimulus(1'b1, 1'b0, 32'h0040_0020, 32'h0, 32'h0BAD_F00D, 1'b0, "l0rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Unified instruction/data memory responder for the multicycle MIPS core, serving the fetch and data accesses requested by the control/datapath side.
- Accepts one word request at a time over a req/ready handshake and inserts a configurable number of wait states.
- Holds a word-addressed RAM array and flags misaligned or out-of-range accesses.
- Sits between the CPU datapath address mux (PC or ALU result) and the instruction register / memory data register.

Parameters:
- WIDTH, 32, data and address width in bits.
- DEPTH, 256, number of words in the array (power of two, ≥2).
- BASE_ADDR, 32'h0040_0000, byte address of word 0.
- LATENCY, 2, wait-state cycles between request capture and the access (0..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  access request, sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  WIDTH  byte address; sampled with req.
- wdata  input  WIDTH  write data; sampled with req.
- rdata  output  WIDTH  registered read data.
- ready  output  1  one-cycle completion pulse.
- err  output  1  error flag for the completing access; valid with ready.
- busy  output  1  high in WAIT and RESP.

Behaviour:
- Reset is rst, asynchronous, active-low. Clock is clk.
- While rst=0: state=IDLE, counter=0, rdata=0, ready=0, err=0, busy=0.
- Array contents are not reset and are retained across reset.
- All outputs are registered.
- FSM states: IDLE, WAIT, RESP.
- IDLE, req=0: remain in IDLE.
- IDLE, req=1: capture we/addr/wdata, load counter=LATENCY, go to WAIT.
- WAIT, counter≠0: decrement counter, stay in WAIT.
- WAIT, counter=0: perform the access on this edge, go to RESP.
  - Access result is registered: ready=1, err updated.
  - Read: rdata = mem[index].
  - Write: mem[index] = wdata; rdata unchanged.
- RESP: ready=1 for exactly this one cycle, then go to IDLE with ready=0.
- Timing: req sampled at edge t → ready high in the cycle after edge t+LATENCY+1.
  - LATENCY=0 → ready high the cycle after the edge following capture, i.e. 2 cycles from request.
- Minimum request spacing is LATENCY+3 cycles.
- req is ignored in WAIT and RESP. A level-held req is recaptured in the next IDLE cycle. There is no queueing.
- Index = (addr − BASE_ADDR) >> 2, modulo-2^WIDTH subtraction.
- Error when addr[1:0]≠0 or index ≥ DEPTH:
  - no write, rdata=0, err=1.
  - the access still takes full latency.
- On a successful access err=0.
- rdata holds its value until the next completed read or errored access.
- err holds until the next completion.
- Reset asserted during WAIT: access abandoned, no write performed, outputs cleared immediately (asynchronous).
- Read of a never-written location returns array contents unspecified. The bench writes before reading.
- Address wrap: addr < BASE_ADDR wraps to a huge index and is therefore an error, never aliased.

Test Plan:
- Reset check: hold rst=0 → rdata=0, ready=0, err=0, busy=0. Release, no req for 5 cycles → all stay 0.
- Write then read, LATENCY=2:
  - req/we=1, addr=0x0040_0008, wdata=0xDEADBEEF → ready pulses 4 cycles after the request cycle, err=0.
  - Then a read of the same address → rdata=0xDEADBEEF with ready.
  - busy is high from the cycle after capture through the ready cycle.
- Misaligned access: write addr=0x0040_0006 → err=1 with ready. A subsequent read of 0x0040_0004 returns its previous contents (unchanged).
- Out of range, DEPTH=256: read addr=0x0040_0400 → err=1, rdata=0. Read addr=0x003F_FFFC → err=1.
- Held req: req=1 continuously with alternating addr 0x0040_0000 / 0x0040_0004 → ready pulses every LATENCY+3=5 cycles. No extra pulses and no dropped accesses.
- Reset mid-WAIT: write 0x12345678 to 0x0040_0010, drop rst one cycle after capture.
  - Outputs clear at once, no ready.
  - After release, a read of 0x0040_0010 returns the value written previously, not 0x12345678.
- LATENCY=0 build: read → ready 2 cycles after the request cycle, with correct rdata.
